// File: rtl/neuron_argmax_collector_if.sv
// Stream and classification signals of neuron_argmax_collector.
// The slave modport is the collector's view. The master modport is the
// environment's view: it drives results and accepts the classification.
interface neuron_argmax_collector_if #(
    parameter int M          = 3,
    parameter int DATA_WIDTH = 8
);
    localparam int RW = 2 * DATA_WIDTH;
    localparam int IW = $clog2(M);

    logic [RW-1:0] in_result;
    logic          in_valid;
    logic          class_valid;
    logic          class_ready;
    logic [IW-1:0] max_idx;
    logic [RW-1:0] max_val;

    modport master (
        output in_result,
        output in_valid,
        output class_ready,
        input  class_valid,
        input  max_idx,
        input  max_val
    );

    modport slave (
        input  in_result,
        input  in_valid,
        input  class_ready,
        output class_valid,
        output max_idx,
        output max_val
    );
endinterface

// File: rtl/neuron_argmax_collector.sv
// neuron_argmax_collector: collects M signed neuron results into a buffer.
// It tracks the running maximum (ties keep the lower index) and presents
// the winning index and value through a valid/ready handshake.
// Optional feature macro ARGMAX_SUM_EN adds sum_out. sum_out is the
// sign-extended running sum of the accepted results.
module neuron_argmax_collector #(
    parameter int M          = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic [$clog2(M)-1:0]           rd_addr,
    output logic [2*DATA_WIDTH-1:0]        rd_data,
    output logic [$clog2(M+1)-1:0]         count,
    output logic                           overrun,
`ifdef ARGMAX_SUM_EN
    output logic [2*DATA_WIDTH+$clog2(M)-1:0] sum_out,
`endif
    neuron_argmax_collector_if.slave       bus
);
    localparam int RW = 2 * DATA_WIDTH;
    localparam int IW = $clog2(M);
    localparam int CW = $clog2(M + 1);
`ifdef ARGMAX_SUM_EN
    localparam int SW = RW + $clog2(M);
`endif

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_REPORT  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [RW-1:0] max_val_q, max_val_d;
    logic [IW-1:0] max_idx_q, max_idx_d;
    logic          overrun_q, overrun_d;
    logic [RW-1:0] rd_data_q;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic          rd_in_range;
`ifdef ARGMAX_SUM_EN
    logic [SW-1:0] sum_q, sum_d;
`endif

    // Result buffer. It has no reset so that it maps onto block RAM.
    logic [RW-1:0] buf_mem [M];

    // While collecting, count_q < M, so its low bits address the buffer directly.
    assign wr_addr = count_q[IW-1:0];

    // M need not be a power of two. Addresses at or above M read as zero.
    assign rd_in_range = ({1'b0, rd_addr} < (IW + 1)'(M));

    // Next-state logic. clear has priority over samples and the handshake.
    // A sample arriving in REPORT is dropped and flagged as overrun.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        overrun_d = overrun_q;
        wr_en     = 1'b0;
`ifdef ARGMAX_SUM_EN
        sum_d     = sum_q;
`endif
        if (clear) begin
            state_d   = ST_COLLECT;
            count_d   = '0;
            max_val_d = '0;
            max_idx_d = '0;
            overrun_d = 1'b0;
`ifdef ARGMAX_SUM_EN
            sum_d     = '0;
`endif
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (bus.in_valid) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                        // The first sample always loads. Later samples replace
                        // the maximum only if strictly greater, so ties keep the
                        // lower index.
                        if ((count_q == '0) ||
                            ($signed(bus.in_result) > $signed(max_val_q))) begin
                            max_val_d = bus.in_result;
                            max_idx_d = wr_addr;
                        end
`ifdef ARGMAX_SUM_EN
                        sum_d = sum_q + {{(SW-RW){bus.in_result[RW-1]}}, bus.in_result};
`endif
                        if (count_q == CW'(M - 1)) begin
                            state_d = ST_REPORT;
                        end
                    end
                end
                ST_REPORT: begin
                    if (bus.in_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (bus.class_ready) begin
                        state_d = ST_COLLECT;
                        count_d = '0;
`ifdef ARGMAX_SUM_EN
                        sum_d   = '0;
`endif
                    end
                end
                default: begin
                    state_d = ST_COLLECT;
                end
            endcase
        end
    end

    // Control and result registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            count_q   <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
            overrun_q <= 1'b0;
`ifdef ARGMAX_SUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
            overrun_q <= overrun_d;
`ifdef ARGMAX_SUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    // Buffer write port. It has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= bus.in_result;
        end
    end

    // Registered read port. A read of the address being written in the same
    // cycle returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_in_range) begin
            rd_data_q <= buf_mem[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data         = rd_data_q;
    assign count           = count_q;
    assign overrun         = overrun_q;
    assign bus.class_valid = (state_q == ST_REPORT);
    assign bus.max_idx     = max_idx_q;
    assign bus.max_val     = max_val_q;
`ifdef ARGMAX_SUM_EN
    assign sum_out         = sum_q;
`endif

endmodule

// File: tb/tb_neuron_argmax_collector.sv
// Directed self-checking bench for neuron_argmax_collector with M=3 and
// DATA_WIDTH=8. Inputs change on the falling edge, and outputs are sampled
// there as well.
module tb_neuron_argmax_collector;
    localparam int M  = 3;
    localparam int DW = 8;
    localparam int RW = 2 * DW;

    logic                 clk;
    logic                 rst_n;
    logic                 clear;
    logic [$clog2(M)-1:0] rd_addr;
    logic [RW-1:0]        rd_data;
    logic [1:0]           count;
    logic                 overrun;
`ifdef ARGMAX_SUM_EN
    logic [RW+$clog2(M)-1:0] sum_out;
`endif

    int n_cmp;
    int n_err;

    neuron_argmax_collector_if #(.M(M), .DATA_WIDTH(DW)) bus ();

    neuron_argmax_collector #(.M(M), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .count   (count),
        .overrun (overrun),
`ifdef ARGMAX_SUM_EN
        .sum_out (sum_out),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle in_valid pulse. Returns on the falling edge after the
    // rising edge that captured the sample.
    task automatic send(input logic [RW-1:0] v);
        @(negedge clk);
        bus.in_result = v;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        $display("send 0x%04h -> count=%0d class_valid=%0b", v, count, bus.class_valid);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        rd_addr = '0;
        bus.in_result = '0;
        bus.in_valid = 1'b0;
        bus.class_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_class_valid", 32'(bus.class_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_max_val", 32'(bus.max_val), 0);
        chk("rst_max_idx", 32'(bus.max_idx), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Basic collection. class_ready is high throughout.
        bus.class_ready = 1'b1;
        send(16'h0005);
        send(16'h0014);
        chk("t1_count2", 32'(count), 2);
        chk("t1_cv_early", 32'(bus.class_valid), 0);
        send(16'h0007);
        chk("t1_cv", 32'(bus.class_valid), 1);
        chk("t1_idx", 32'(bus.max_idx), 1);
        chk("t1_val", 32'(bus.max_val), 32'h0014);
        chk("t1_count3", 32'(count), 3);
`ifdef ARGMAX_SUM_EN
        chk("t1_sum", 32'(sum_out), 32'h0020);
`endif
        @(negedge clk);
        chk("t1_cv_drop", 32'(bus.class_valid), 0);
        chk("t1_count0", 32'(count), 0);

        // 2. Signed comparison
        send(16'hFFFD);
        send(16'hFFFF);
        send(16'hFFF8);
        chk("t2a_idx", 32'(bus.max_idx), 1);
        chk("t2a_val", 32'(bus.max_val), 32'hFFFF);
`ifdef ARGMAX_SUM_EN
        chk("t2a_sum", 32'(sum_out), 32'h3FFF4);
`endif
        @(negedge clk);
        send(16'h8000);
        send(16'h0000);
        send(16'h7FFF);
        chk("t2b_idx", 32'(bus.max_idx), 2);
        chk("t2b_val", 32'(bus.max_val), 32'h7FFF);
        @(negedge clk);

        // 3. Tie handling and buffer readback
        bus.class_ready = 1'b0;
        send(16'h0009);
        send(16'h0009);
        send(16'h0004);
        chk("t3_idx", 32'(bus.max_idx), 0);
        chk("t3_val", 32'(bus.max_val), 9);
        rd_addr = 2'd0;
        @(negedge clk);
        chk("t3_rd0", 32'(rd_data), 9);
        rd_addr = 2'd1;
        @(negedge clk);
        chk("t3_rd1", 32'(rd_data), 9);
        rd_addr = 2'd2;
        @(negedge clk);
        chk("t3_rd2", 32'(rd_data), 4);
        rd_addr = 2'd3;
        @(negedge clk);
        chk("t3_rd3", 32'(rd_data), 0);
        bus.class_ready = 1'b1;
        @(negedge clk);
        bus.class_ready = 1'b0;
        chk("t3_cv_drop", 32'(bus.class_valid), 0);

        // 4. Backpressure, with a sample that overruns
        send(16'h0010);
        send(16'h0020);
        send(16'h0030);
        repeat (5) @(negedge clk);
        chk("t4_cv_hold", 32'(bus.class_valid), 1);
        chk("t4_val_hold", 32'(bus.max_val), 32'h0030);
        chk("t4_ovr_pre", 32'(overrun), 0);
        send(16'h0063);
        chk("t4_ovr", 32'(overrun), 1);
        chk("t4_cv", 32'(bus.class_valid), 1);
        chk("t4_idx", 32'(bus.max_idx), 2);
        chk("t4_val", 32'(bus.max_val), 32'h0030);
        chk("t4_count", 32'(count), 3);
        rd_addr = 2'd0;
        @(negedge clk);
        chk("t4_buf0", 32'(rd_data), 32'h0010);
        bus.class_ready = 1'b1;
        @(negedge clk);
        bus.class_ready = 1'b0;
        chk("t4_cv_drop", 32'(bus.class_valid), 0);
        chk("t4_ovr_sticky", 32'(overrun), 1);

        // 5. clear in the middle of a collection
        send(16'h0030);
        send(16'h0040);
        chk("t5_count2", 32'(count), 2);
        @(negedge clk);
        clear = 1'b1;
        bus.in_result = 16'h0050;
        bus.in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_count0", 32'(count), 0);
        chk("t5_val0", 32'(bus.max_val), 0);
        chk("t5_cv0", 32'(bus.class_valid), 0);
        chk("t5_ovr0", 32'(overrun), 0);
        send(16'h0001);
        send(16'h0002);
        send(16'h0003);
        chk("t5_idx", 32'(bus.max_idx), 2);
        chk("t5_val", 32'(bus.max_val), 3);

        // 6. Asynchronous reset while in REPORT
        chk("t6_cv_pre", 32'(bus.class_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_cv", 32'(bus.class_valid), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_val", 32'(bus.max_val), 0);
        chk("t6_idx", 32'(bus.max_idx), 0);
        chk("t6_rd", 32'(rd_data), 0);
`ifdef ARGMAX_SUM_EN
        chk("t6_sum_rst", 32'(sum_out), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0007);
        send(16'h0001);
        send(16'h0002);
        chk("t6_idx_after", 32'(bus.max_idx), 0);
        chk("t6_val_after", 32'(bus.max_val), 7);
`ifdef ARGMAX_SUM_EN
        chk("t6_sum", 32'(sum_out), 10);
`endif
        bus.class_ready = 1'b1;
        @(negedge clk);
        chk("t6_cv_drop", 32'(bus.class_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
